// File: rtl/setup_stim_pkg.sv
// rtl/setup_stim_pkg.sv - shared state encoding and default widths for the setup stimulus generator
package setup_stim_pkg;

  localparam int SEP_W_DEF = 8;
  localparam int CNT_W_DEF = 8;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_DATA = 3'd1;
  localparam state_t ST_SEP  = 3'd2;
  localparam state_t ST_REF  = 3'd3;
  localparam state_t ST_GAP  = 3'd4;
  localparam state_t ST_FIN  = 3'd5;

endpackage

// File: rtl/setup_stim_gen_if.sv
// rtl/setup_stim_gen_if.sv - launch/config and stimulus output bundle of the setup stimulus generator
interface setup_stim_gen_if
  import setup_stim_pkg::*;
#(
  parameter int SEP_W = SEP_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) ();

  logic             start;
  logic [SEP_W-1:0] sep_cycles;
  logic [SEP_W-1:0] limit_cycles;
  logic [SEP_W-1:0] gap_cycles;
  logic [CNT_W-1:0] num_pairs;
  logic             data_out;
  logic             ref_out;
  logic             busy;
  logic             done;
  logic             exp_viol;
  logic [CNT_W-1:0] viol_count;

  modport master (
    output start, sep_cycles, limit_cycles, gap_cycles, num_pairs,
    input  data_out, ref_out, busy, done, exp_viol, viol_count
  );

  modport slave (
    input  start, sep_cycles, limit_cycles, gap_cycles, num_pairs,
    output data_out, ref_out, busy, done, exp_viol, viol_count
  );

endinterface

// File: rtl/cycle_down_counter.sv
// rtl/cycle_down_counter.sv - loadable down-counter with zero flag, shared by the SEP and GAP waits
module cycle_down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/setup_stim_gen.sv
// rtl/setup_stim_gen.sv - generates data/reference edge pairs with programmable separation and
// flags the reference edges that fall inside the setup limit
module setup_stim_gen
  import setup_stim_pkg::*;
#(
  parameter int SEP_W = SEP_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  setup_stim_gen_if.slave bus
);

  state_t           state_q;
  logic [SEP_W-1:0] sep_q;
  logic [SEP_W-1:0] lim_q;
  logic [SEP_W-1:0] gap_q;
  logic [CNT_W-1:0] left_q;
  logic             data_q;
  logic             ref_q;
  logic             busy_q;
  logic             done_q;
  logic             viol_q;
  logic [CNT_W-1:0] vcnt_q;

  logic             cnt_load;
  logic             cnt_dec;
  logic [SEP_W-1:0] cnt_val;
  logic             cnt_zero;
  logic             ref_now;
  state_t           after_ref;

  // A zero separation folds the reference toggle into the data edge.
  assign ref_now = (state_q == ST_REF) ||
                   ((state_q == ST_DATA) && (left_q != '0) && (sep_q == '0));

  // The last pair skips the gap so done lands one edge after its reference toggle.
  assign after_ref = ((left_q == CNT_W'(1)) || (gap_q == '0)) ? ST_DATA : ST_GAP;

  // SEP preloads sep-2 because entering and leaving the wait each cost one edge; GAP preloads gap-1.
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = '0;
    if ((state_q == ST_DATA) && (left_q != '0) && (sep_q > SEP_W'(1))) begin
      cnt_load = 1'b1;
      cnt_val  = sep_q - SEP_W'(2);
    end else if (ref_now && (after_ref == ST_GAP)) begin
      cnt_load = 1'b1;
      cnt_val  = gap_q - SEP_W'(1);
    end
  end

  assign cnt_dec = (state_q == ST_SEP) || (state_q == ST_GAP);

  cycle_down_counter #(.W(SEP_W)) u_wait (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sep_q   <= '0;
      lim_q   <= '0;
      gap_q   <= '0;
      left_q  <= '0;
      data_q  <= 1'b0;
      ref_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      viol_q  <= 1'b0;
      vcnt_q  <= '0;
    end else begin
      done_q <= 1'b0;
      viol_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            sep_q   <= bus.sep_cycles;
            lim_q   <= bus.limit_cycles;
            gap_q   <= bus.gap_cycles;
            left_q  <= bus.num_pairs;
            vcnt_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (left_q == '0) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_FIN;
          end else begin
            data_q <= ~data_q;
            if (sep_q == '0)
              state_q <= after_ref;
            else if (sep_q == SEP_W'(1))
              state_q <= ST_REF;
            else
              state_q <= ST_SEP;
          end
        end
        ST_SEP:  if (cnt_zero) state_q <= ST_REF;
        ST_REF:  state_q <= after_ref;
        ST_GAP:  if (cnt_zero) state_q <= ST_DATA;
        ST_FIN:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase

      if (ref_now) begin
        ref_q  <= ~ref_q;
        left_q <= left_q - CNT_W'(1);
        if (sep_q < lim_q) begin
          viol_q <= 1'b1;
          if (vcnt_q != '1)
            vcnt_q <= vcnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign bus.data_out   = data_q;
  assign bus.ref_out    = ref_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.exp_viol   = viol_q;
  assign bus.viol_count = vcnt_q;

endmodule

// File: tb/tb_setup_stim_gen.sv
// tb/tb_setup_stim_gen.sv - scoreboard bench for setup_stim_gen
module tb_setup_stim_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  setup_stim_gen_if #(.SEP_W(8), .CNT_W(8)) bus ();

  setup_stim_gen #(.SEP_W(8), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int cyc;
    bit dt;
    bit rt;
    bit ev;
    bit dn;
    int vc;
  } ev_t;

  ev_t q[$];
  int  cyc = 0;
  int  n_checks = 0;
  int  n_pass = 0;
  logic pd = 1'b0;
  logic pr = 1'b0;
  bit  m_dt, m_rt;
  ev_t m_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // monitor: every visible event pops one scoreboard entry
  always @(negedge clk) begin
    if (rst) begin
      pd = 1'b0;
      pr = 1'b0;
    end else begin
      m_dt = bus.data_out ^ pd;
      m_rt = bus.ref_out ^ pr;
      pd = bus.data_out;
      pr = bus.ref_out;
      if (m_dt || m_rt || bus.exp_viol || bus.done) begin
        n_checks++;
        if (q.size() == 0) begin
          $display("FAIL unexpected_event: got cyc=%0d dt=%0b rt=%0b ev=%0b dn=%0b vc=%0d, expected none",
                   cyc, m_dt, m_rt, bus.exp_viol, bus.done, bus.viol_count);
        end else begin
          m_e = q.pop_front();
          if (m_e.cyc == cyc && m_e.dt == m_dt && m_e.rt == m_rt && m_e.ev == bus.exp_viol &&
              m_e.dn == bus.done && m_e.vc == int'(bus.viol_count))
            n_pass++;
          else
            $display("FAIL event: got cyc=%0d dt=%0b rt=%0b ev=%0b dn=%0b vc=%0d, expected cyc=%0d dt=%0b rt=%0b ev=%0b dn=%0b vc=%0d",
                     cyc, m_dt, m_rt, bus.exp_viol, bus.done, bus.viol_count,
                     m_e.cyc, m_e.dt, m_e.rt, m_e.ev, m_e.dn, m_e.vc);
        end
      end
    end
  end

  task automatic push(input int k, input int off, input bit dt, input bit rt, input bit ev,
                      input bit dn, input int vc);
    ev_t e;
    e.cyc = k + off; e.dt = dt; e.rt = rt; e.ev = ev; e.dn = dn; e.vc = vc;
    q.push_back(e);
  endtask

  task automatic launch(input int s, input int l, input int g, input int p, output int k);
    @(negedge clk);
    bus.sep_cycles   = s[7:0];
    bus.limit_cycles = l[7:0];
    bus.gap_cycles   = g[7:0];
    bus.num_pairs    = p[7:0];
    bus.start        = 1'b1;
    k = cyc + 1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, q.size(), 0);
    q.delete();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int k;
    bus.start = 1'b0;
    bus.sep_cycles = '0;
    bus.limit_cycles = '0;
    bus.gap_cycles = '0;
    bus.num_pairs = '0;
    repeat (3) @(negedge clk);
    chk("rst_data", bus.data_out, 0);
    chk("rst_ref", bus.ref_out, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_viol", bus.exp_viol, 0);
    chk("rst_vcnt", bus.viol_count, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // two violating pairs with a one-cycle gap
    launch(3, 5, 1, 2, k);
    chk("busy_after_launch", bus.busy, 1);
    push(k, 1, 1, 0, 0, 0, 0);
    push(k, 4, 0, 1, 1, 0, 1);
    push(k, 6, 1, 0, 0, 0, 1);
    push(k, 9, 0, 1, 1, 0, 2);
    push(k, 10, 0, 0, 0, 1, 2);
    drain("drain_t1", 40);
    chk("vcnt_t1", bus.viol_count, 2);
    chk("busy_idle_t1", bus.busy, 0);

    // sep equal to limit is not a violation
    launch(5, 5, 0, 1, k);
    push(k, 1, 1, 0, 0, 0, 0);
    push(k, 6, 0, 1, 0, 0, 0);
    push(k, 7, 0, 0, 0, 1, 0);
    drain("drain_t2", 40);

    // zero separation: both edges together
    launch(0, 1, 0, 1, k);
    push(k, 1, 1, 1, 1, 0, 1);
    push(k, 2, 0, 0, 0, 1, 1);
    drain("drain_t3", 40);

    // no pairs
    launch(0, 0, 0, 0, k);
    push(k, 1, 0, 0, 0, 1, 0);
    drain("drain_t4", 40);

    // start and config changes while busy are ignored
    launch(2, 1, 2, 2, k);
    push(k, 1, 1, 0, 0, 0, 0);
    push(k, 3, 0, 1, 0, 0, 0);
    push(k, 6, 1, 0, 0, 0, 0);
    push(k, 8, 0, 1, 0, 0, 0);
    push(k, 9, 0, 0, 0, 1, 0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.sep_cycles = 8'd0;
    bus.limit_cycles = 8'd9;
    bus.num_pairs = 8'd9;
    repeat (3) @(negedge clk);
    bus.start = 1'b0;
    drain("drain_t5", 40);

    // full-scale separation
    launch(255, 255, 0, 1, k);
    push(k, 1, 1, 0, 0, 0, 0);
    push(k, 256, 0, 1, 0, 0, 0);
    push(k, 257, 0, 0, 0, 1, 0);
    drain("drain_sep_full", 300);

    // full-scale gap
    launch(1, 0, 255, 2, k);
    push(k, 1, 1, 0, 0, 0, 0);
    push(k, 2, 0, 1, 0, 0, 0);
    push(k, 258, 1, 0, 0, 0, 0);
    push(k, 259, 0, 1, 0, 0, 0);
    push(k, 260, 0, 0, 0, 1, 0);
    drain("drain_gap_full", 300);

    // reset during the SEP wait of pair 2
    launch(4, 0, 0, 3, k);
    push(k, 1, 1, 0, 0, 0, 0);
    push(k, 5, 0, 1, 0, 0, 0);
    push(k, 6, 1, 0, 0, 0, 0);
    while (cyc < k + 7) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_ref", bus.ref_out, 0);
    chk("abort_data", bus.data_out, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_queue", q.size(), 0);
    q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    launch(5, 5, 0, 1, k);
    push(k, 1, 1, 0, 0, 0, 0);
    push(k, 6, 0, 1, 0, 0, 0);
    push(k, 7, 0, 0, 0, 1, 0);
    drain("drain_post_rst", 40);

    // 255 violating pairs, then a fresh start clears the count
    launch(1, 2, 0, 255, k);
    for (int i = 0; i < 255; i++) begin
      push(k, 1 + 2 * i, 1, 0, 0, 0, i);
      push(k, 2 + 2 * i, 0, 1, 1, 0, i + 1);
    end
    push(k, 511, 0, 0, 0, 1, 255);
    drain("drain_255", 600);
    chk("vcnt_255", bus.viol_count, 255);
    launch(0, 0, 0, 0, k);
    chk("vcnt_cleared", bus.viol_count, 0);
    push(k, 1, 0, 0, 0, 1, 0);
    drain("drain_clear", 40);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/setup_stim_gen.md
SETUP_STIM_GEN -- requirements
Module: setup_stim_gen

Interface
REQ-001 Parameter SEP_W, default 8, width of sep_cycles, limit_cycles and gap_cycles.
REQ-002 Parameter CNT_W, default 8, width of num_pairs and viol_count.
REQ-003 clk  input  1  the block's only clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  launch request; sampled only in IDLE.
REQ-006 sep_cycles  input  SEP_W  cycles from the data edge to the reference edge.
REQ-007 limit_cycles  input  SEP_W  required setup limit in cycles.
REQ-008 gap_cycles  input  SEP_W  idle cycles between a reference edge and the next data edge.
REQ-009 num_pairs  input  CNT_W  number of data/reference edge pairs to generate.
REQ-010 data_out  output  1  data signal; toggles once per pair.
REQ-011 ref_out  output  1  reference signal; toggles once per pair.
REQ-012 busy  output  1  high while a sequence is in progress.
REQ-013 done  output  1  one-cycle pulse at sequence end.
REQ-014 exp_viol  output  1  one-cycle pulse coincident with a reference toggle that must be flagged as a setup violation.
REQ-015 viol_count  output  CNT_W  count of exp_viol pulses in the current or most recent sequence.

Function
REQ-016 FSM states: IDLE, DATA, SEP, REF, GAP, FIN.
REQ-017 In IDLE with start=1 at edge k: latch all config inputs, clear viol_count, set busy=1 after edge k.
REQ-018 Config inputs are ignored between launch and return to IDLE; start while busy is ignored.
REQ-019 data_out toggles at edge k+1 for the first pair.
REQ-020 ref_out toggles at edge D+sep, where D is the edge at which data_out toggled for that pair.
REQ-021 With sep=0, data_out and ref_out toggle at the same edge.
REQ-022 exp_viol is high for the cycle after the ref toggle edge iff latched sep < latched limit (unsigned).
REQ-023 viol_count increments at the same edge; it saturates at all-ones and does not wrap.
REQ-024 The next pair's data toggle occurs at edge R+1+gap, where R is the previous ref toggle edge.
REQ-025 After the last pair's ref edge R, FIN: done=1 and busy=0 after edge R+1; state returns to IDLE at edge R+2.
REQ-026 If num_pairs=0 at launch: no toggles, done=1 and busy=0 after edge k+1.
REQ-027 done and start may coincide on the IDLE-return cycle; start is honoured only once state is IDLE.
REQ-028 All SEP_W-wide waits use a single down-counter; full-scale values (all-ones) are legal.

Reset
REQ-029 While rst is high: state=IDLE, data_out=0, ref_out=0, busy=0, done=0, exp_viol=0, viol_count=0, counters=0.
REQ-030 Reset mid-sequence aborts immediately with no done pulse; the first edge after release starts in IDLE.

Structure
REQ-031 Shared package setup_stim_pkg holds the state enum and the default SEP_W/CNT_W constants.
REQ-032 One sub-module, cycle_down_counter (load, decrement, zero flag), shared by the SEP and GAP waits.

Verification
REQ-033 sep=3, limit=5, gap=1, pairs=2, start at edge 0 -> data toggles at edges 1,6; ref toggles at edges 4,9; exp_viol pulses twice; done after edge 10; viol_count=2.
REQ-034 sep=5, limit=5, pairs=1 -> no exp_viol (equal is not a violation); viol_count=0; done after edge 7.
REQ-035 sep=0, limit=1, pairs=1 -> data_out and ref_out toggle at edge 1; exp_viol=1; done after edge 2.
REQ-036 pairs=0 -> no toggles; done after edge 1; start pulsed while busy in another run has no effect.
REQ-037 rst asserted during SEP of pair 2 -> all outputs 0 asynchronously; no done; a new start after release runs a clean sequence.
REQ-038 Run with 255 violating pairs -> viol_count=255 after the run; a subsequent start clears it to 0.
